lsu_align_unit: RTL and testbench

- Load/store alignment unit between the execute stage (ALU address, rs2 data, funct3) and the word-wide data RAM.
- Accepts one byte, halfword or word access per request.
- Splits any access that crosses a 32-bit word boundary into two aligned word accesses with byte enables.
- Assembles and sign/zero-extends load data, and returns a single completion response.

---
 rtl/lsu_align_unit.sv | 157 +++++++++++++++
 tb/tb_lsu_align_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit: splits word-crossing accesses into two aligned RAM
// accesses, merges load bytes and returns one extended completion response.
module lsu_align_unit #(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // state | meaning
  // IDLE  | ready for a request
  // ACC0  | access to the word holding the first byte
  // ACC1  | access to the following word (crossing requests only)
  // RESP  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      state, state_nxt;
  logic        we_q, err_q;
  logic [2:0]  func3_q;
  logic [31:0] addr_q, wdata_q, asm_q;

  function automatic logic [2:0] size_of(input logic [1:0] f);
    logic [2:0] s;
    case (f)
      2'b00:   s = 3'd1;
      2'b01:   s = 3'd2;
      default: s = 3'd4;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] mask_of(input logic [1:0] f);
    logic [3:0] m;
    case (f)
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic is_cross(input logic [1:0] f, input logic [1:0] off);
    return ({1'b0, off} + size_of(f)) > 3'd4;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f, input logic [31:0] a);
    logic [31:0] r;
    case (f[1:0])
      2'b00:   r = f[2] ? {24'h0, a[7:0]}  : {{24{a[7]}}, a[7:0]};
      2'b01:   r = f[2] ? {16'h0, a[15:0]} : {{16{a[15]}}, a[15:0]};
      default: r = a;
    endcase
    return r;
  endfunction

  logic        accept, req_cross, cross_q;
  logic [1:0]  off_q;
  logic [2:0]  rem_q;
  logic [7:0]  mask8;
  logic [63:0] wdata64;
  logic [31:0] rdata_lo, rdata_hi;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign req_cross = is_cross(req_func3[1:0], req_addr[1:0]);
  assign off_q     = addr_q[1:0];
  assign rem_q     = 3'd4 - {1'b0, off_q};
  assign cross_q   = is_cross(func3_q[1:0], off_q);
  // Upper halves of the shifted mask/data are exactly the second-word lanes.
  assign mask8     = {4'b0000, mask_of(func3_q[1:0])} << off_q;
  assign wdata64   = {32'h0, wdata_q} << {off_q, 3'b000};
  assign rdata_lo  = mem_rdata >> {off_q, 3'b000};
  assign rdata_hi  = mem_rdata << {rem_q, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 4'b0000;
    mem_addr   = 30'h0;
    mem_wdata  = 32'h0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    case (state)
      IDLE: begin
        if (req_valid) state_nxt = (!MISALIGN_EN && req_cross) ? RESP : ACC0;
      end
      ACC0: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_be    = mask8[3:0];
        mem_addr  = addr_q[31:2];
        mem_wdata = wdata64[31:0];
        state_nxt = cross_q ? ACC1 : RESP;
      end
      ACC1: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_be    = mask8[7:4];
        mem_addr  = addr_q[31:2] + 30'd1;
        mem_wdata = wdata64[63:32];
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!we_q && !err_q) resp_rdata = extend(func3_q, asm_q);
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      func3_q <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      asm_q   <= 32'h0;
    end else if (accept) begin
      we_q    <= req_we;
      err_q   <= !MISALIGN_EN && req_cross;
      func3_q <= req_func3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      asm_q   <= 32'h0;
    end else if (state == ACC0 && !we_q) begin
      asm_q <= rdata_lo;
    end else if (state == ACC1 && !we_q) begin
      asm_q <= asm_q | rdata_hi;
    end
  end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Self-checking bench for lsu_align_unit: directed plan cases plus randomized
// requests checked against a byte-addressed memory model.
module tb_lsu_align_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, mem_en, mem_we;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;

  logic        req_valid_nm, req_ready_nm, resp_valid_nm, resp_err_nm, mem_en_nm, mem_we_nm;
  logic [31:0] resp_rdata_nm, mem_wdata_nm, mem_rdata_nm;
  logic [3:0]  mem_be_nm;
  logic [29:0] mem_addr_nm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_align_unit #(.MISALIGN_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  lsu_align_unit #(.MISALIGN_EN(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_nm), .req_ready(req_ready_nm),
    .req_we(req_we), .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_nm), .resp_rdata(resp_rdata_nm), .resp_err(resp_err_nm),
    .mem_en(mem_en_nm), .mem_we(mem_we_nm), .mem_be(mem_be_nm), .mem_addr(mem_addr_nm),
    .mem_wdata(mem_wdata_nm), .mem_rdata(mem_rdata_nm)
  );

  // 16-word RAM; word address aliases modulo 16 so the top word sits at index 15.
  logic [31:0] ram [16];
  logic [31:0] init_image [16];
  logic [31:0] model_words [16];
  logic        ram_init = 1'b0;

  always @(posedge clk) begin
    if (ram_init) ram <= init_image;
    else if (mem_en && mem_we)
      for (int j = 0; j < 4; j++)
        if (mem_be[j]) ram[mem_addr[3:0]][8*j +: 8] <= mem_wdata[8*j +: 8];
  end
  assign mem_rdata = ram[mem_addr[3:0]];

  int          r_lat, r_nacc;
  logic [3:0]  r_be0, r_be1;
  logic [29:0] r_a0, r_a1;
  logic [31:0] r_wd0, r_wd1, r_rdata;
  logic [1:0]  r_mwe;
  logic        r_err, r_extra;

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    return model_words[a[5:2]][8*a[1:0] +: 8];
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] be);
    logic [31:0] m;
    for (int j = 0; j < 4; j++) m[8*j +: 8] = {8{be[j]}};
    return m;
  endfunction

  task automatic preload();
    init_image = model_words;
    ram_init = 1'b1;
    @(posedge clk); #1;
    ram_init = 1'b0;
    @(negedge clk);
  endtask

  task automatic plan_image();
    for (int j = 0; j < 16; j++) model_words[j] = 32'h0;
    model_words[0]  = 32'h44332211;
    model_words[1]  = 32'h88776655;
    model_words[15] = 32'hDEADBEEF;
    preload();
  endtask

  // Issues one request on the main unit and records what it observes; r_lat = -1 on timeout.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
    int w;
    r_lat = -1; r_nacc = 0; r_be0 = 0; r_be1 = 0; r_a0 = 0; r_a1 = 0;
    r_wd0 = 0; r_wd1 = 0; r_rdata = 0; r_mwe = 0; r_err = 0; r_extra = 0;
    w = 0;
    while (!req_ready && w < 10) begin @(negedge clk); w++; end
    if (!req_ready) return;
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_func3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_en) begin
        if (r_nacc == 0) begin r_be0 = mem_be; r_a0 = mem_addr; r_wd0 = mem_wdata; r_mwe[0] = mem_we; end
        else if (r_nacc == 1) begin r_be1 = mem_be; r_a1 = mem_addr; r_wd1 = mem_wdata; r_mwe[1] = mem_we; end
        r_nacc++;
      end
      if (resp_valid) begin r_lat = c; r_rdata = resp_rdata; r_err = resp_err; break; end
    end
    if (r_lat > 0) begin @(negedge clk); r_extra = resp_valid; end
  endtask

  task automatic test_reset();
    logic [101:0] obs;
    rst_n = 1'b0; req_valid = 0; req_valid_nm = 0; req_we = 0; req_func3 = 0;
    req_addr = 0; req_wdata = 0; mem_rdata_nm = 32'h12345678;
    #12;
    obs = {resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata};
    checks++; if (obs !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", obs); end
    checks++; if (req_ready !== 1'b1 || req_ready_nm !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b/%b exp 1/1", req_ready, req_ready_nm); end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask

  task automatic test_lw_aligned();
    run_req(1'b0, 3'b010, 32'h0, 32'h0);
    checks++; if (r_lat !== 2) begin errors++; $display("FAIL lw_lat got %0d exp 2", r_lat); end
    checks++; if (r_nacc !== 1) begin errors++; $display("FAIL lw_nacc got %0d exp 1", r_nacc); end
    checks++; if (r_be0 !== 4'b1111 || r_a0 !== 30'h0) begin errors++; $display("FAIL lw_be_addr got %b/%h exp 1111/0", r_be0, r_a0); end
    checks++; if (r_rdata !== 32'h44332211 || r_err !== 1'b0) begin errors++; $display("FAIL lw_rdata got %h err %b exp 44332211 err 0", r_rdata, r_err); end
    checks++; if (r_extra !== 1'b0) begin errors++; $display("FAIL lw_single_pulse got %b exp 0", r_extra); end
  endtask

  task automatic test_lh_cross();
    run_req(1'b0, 3'b001, 32'h3, 32'h0);
    checks++; if (r_lat !== 3 || r_nacc !== 2) begin errors++; $display("FAIL lh_lat_nacc got %0d/%0d exp 3/2", r_lat, r_nacc); end
    checks++; if (r_be0 !== 4'b1000 || r_a0 !== 30'h0 || r_be1 !== 4'b0001 || r_a1 !== 30'h1) begin
      errors++; $display("FAIL lh_access got %b@%h %b@%h exp 1000@0 0001@1", r_be0, r_a0, r_be1, r_a1); end
    checks++; if (r_rdata !== 32'h00005544) begin errors++; $display("FAIL lh_rdata got %h exp 00005544", r_rdata); end
  endtask

  task automatic test_lb();
    run_req(1'b0, 3'b000, 32'h7, 32'h0);
    checks++; if (r_rdata !== 32'hFFFFFF88 || r_nacc !== 1 || r_be0 !== 4'b1000 || r_a0 !== 30'h1) begin
      errors++; $display("FAIL lb_signed got %h n%0d %b@%h exp FFFFFF88 n1 1000@1", r_rdata, r_nacc, r_be0, r_a0); end
    run_req(1'b0, 3'b100, 32'h7, 32'h0);
    checks++; if (r_rdata !== 32'h00000088 || r_lat !== 2) begin
      errors++; $display("FAIL lbu got %h lat %0d exp 00000088 lat 2", r_rdata, r_lat); end
  endtask

  task automatic test_wrap();
    run_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
    checks++; if (r_a0 !== 30'h3FFFFFFF || r_a1 !== 30'h0 || r_nacc !== 2) begin
      errors++; $display("FAIL wrap_addr got %h/%h n%0d exp 3fffffff/0 n2", r_a0, r_a1, r_nacc); end
    checks++; if (r_be0 !== 4'b1100 || r_be1 !== 4'b0011 || r_rdata !== 32'h2211DEAD) begin
      errors++; $display("FAIL wrap_data got %b %b %h exp 1100 0011 2211dead", r_be0, r_be1, r_rdata); end
  endtask

  task automatic test_sw_cross();
    run_req(1'b1, 3'b010, 32'h2, 32'hAABBCCDD);
    checks++; if (r_be0 !== 4'b1100 || (r_wd0 & 32'hFFFF0000) !== 32'hCCDD0000) begin
      errors++; $display("FAIL sw_acc0 got %b %h exp 1100 ccdd0000", r_be0, r_wd0); end
    checks++; if (r_be1 !== 4'b0011 || (r_wd1 & 32'h0000FFFF) !== 32'h0000AABB) begin
      errors++; $display("FAIL sw_acc1 got %b %h exp 0011 0000aabb", r_be1, r_wd1); end
    checks++; if (r_mwe !== 2'b11 || r_lat !== 3 || r_rdata !== 32'h0) begin
      errors++; $display("FAIL sw_resp got we %b lat %0d rdata %h exp 11 3 0", r_mwe, r_lat, r_rdata); end
    checks++; if (ram[0] !== 32'hCCDD2211 || ram[1] !== 32'h8877AABB) begin
      errors++; $display("FAIL sw_ram got %h %h exp ccdd2211 8877aabb", ram[0], ram[1]); end
  endtask

  task automatic test_reject();
    int en_cnt;
    logic [3:1] rvv;
    logic e1, m1ok;
    logic [31:0] d1;
    en_cnt = 0; rvv = 0; e1 = 0; d1 = 32'hx; m1ok = 0;
    req_valid_nm = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h1;
    @(posedge clk); #1; req_valid_nm = 1'b0; req_addr = $urandom;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (mem_en_nm || mem_we_nm || mem_be_nm != 4'b0) en_cnt++;
      rvv[c] = resp_valid_nm;
      if (c == 1) begin e1 = resp_err_nm; d1 = resp_rdata_nm; end
    end
    checks++; if (en_cnt !== 0) begin errors++; $display("FAIL rej_no_mem got %0d exp 0", en_cnt); end
    checks++; if (rvv !== 3'b001 || e1 !== 1'b1 || d1 !== 32'h0) begin
      errors++; $display("FAIL rej_resp got valid %b err %b rdata %h exp 001 1 0", rvv, e1, d1); end
    req_valid_nm = 1'b1; req_func3 = 3'b010; req_addr = 32'h4;
    @(posedge clk); #1; req_valid_nm = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      if (c == 1) m1ok = mem_en_nm && mem_addr_nm == 30'h1 && mem_be_nm == 4'hF;
      if (c == 2) begin e1 = resp_err_nm; d1 = resp_rdata_nm; rvv[1] = resp_valid_nm; end
    end
    checks++; if (!m1ok || rvv[1] !== 1'b1 || e1 !== 1'b0 || d1 !== 32'h12345678) begin
      errors++; $display("FAIL nm_aligned got mem %b valid %b err %b rdata %h exp 1 1 0 12345678", m1ok, rvv[1], e1, d1); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [6:1] rdy, rv;
    logic [31:0] d2, d5;
    logic [29:0] ma1, ma4;
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h0; req_wdata = 0;
    @(posedge clk); #1; req_addr = 32'h4;
    d2 = 0; d5 = 0; ma1 = 0; ma4 = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      rdy[c] = req_ready; rv[c] = resp_valid;
      if (c == 1) ma1 = mem_addr;
      if (c == 2) d2 = resp_rdata;
      if (c == 4) ma4 = mem_addr;
      if (c == 5) d5 = resp_rdata;
      if (c == 3) begin @(posedge clk); #1; req_valid = 1'b0; end
    end
    checks++; if (rdy !== 6'b100100) begin errors++; $display("FAIL b2b_ready got %b exp 100100", rdy); end
    checks++; if (rv !== 6'b010010) begin errors++; $display("FAIL b2b_resp got %b exp 010010", rv); end
    checks++; if (d2 !== 32'h44332211 || d5 !== 32'h88776655 || ma1 !== 30'h0 || ma4 !== 30'h1) begin
      errors++; $display("FAIL b2b_data got %h %h @%h @%h exp 44332211 88776655 @0 @1", d2, d5, ma1, ma4); end
  endtask

  task automatic test_reset_acc1();
    logic [101:0] obs;
    logic a0ok, a1ok, seen;
    req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010; req_addr = 32'h2; req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk); a0ok = mem_en && mem_be == 4'b1100;
    @(negedge clk); a1ok = mem_en && mem_be == 4'b0011;
    #2 rst_n = 1'b0; #1;
    obs = {resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata};
    checks++; if (!a0ok || !a1ok) begin errors++; $display("FAIL rst_acc1_setup got %b%b exp 11", a0ok, a1ok); end
    checks++; if (obs !== '0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_acc1_outputs got %h ready %b exp 0 ready 1", obs, req_ready); end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 3; c++) begin @(negedge clk); seen |= resp_valid; end
    checks++; if (ram[0] !== 32'hCCDD2211 || ram[1] !== 32'h88776655) begin
      errors++; $display("FAIL rst_acc1_ram got %h %h exp ccdd2211 88776655", ram[0], ram[1]); end
    checks++; if (seen !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_acc1_noresp got resp %b ready %b exp 0 1", seen, req_ready); end
  endtask

  task automatic test_random();
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wd, last, b, d, lm;
    logic [63:0] v;
    logic [29:0] w [2];
    logic [3:0]  ebe [2];
    logic [31:0] ewd [2];
    logic [31:0] exp_rd;
    int size, nexp;
    for (int j = 0; j < 16; j++) model_words[j] = $urandom;
    preload();
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom); f3 = 3'($urandom); wd = $urandom;
      if ($urandom_range(0, 3) == 0) addr = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
      else addr = 32'($urandom_range(0, 63));
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      last = addr + 32'(size - 1);
      nexp = (last[31:2] != addr[31:2]) ? 2 : 1;
      w[0] = addr[31:2]; w[1] = addr[31:2] + 30'd1;
      for (int k = 0; k < 2; k++) begin
        ebe[k] = 4'b0; ewd[k] = 32'h0;
        for (int j = 0; j < 4; j++) begin
          b = {w[k], 2'(j)};
          d = b - addr;
          if (k < nexp && d < 32'(size)) begin
            ebe[k][j] = 1'b1;
            ewd[k][8*j +: 8] = wd[8*int'(d) +: 8];
          end
        end
      end
      v = 64'h0;
      for (int i = 0; i < size; i++) v |= {56'h0, mbyte(addr + 32'(i))} << (8*i);
      if (!f3[2] && v[8*size-1]) v |= ~((64'd1 << (8*size)) - 64'd1);
      exp_rd = we ? 32'h0 : v[31:0];
      run_req(we, f3, addr, wd);
      checks++; if (r_lat !== nexp + 1 || r_nacc !== nexp) begin
        errors++; $display("FAIL rnd_timing #%0d got lat %0d n %0d exp %0d %0d", n, r_lat, r_nacc, nexp + 1, nexp); end
      checks++; if (r_be0 !== ebe[0] || r_a0 !== w[0]) begin
        errors++; $display("FAIL rnd_acc0 #%0d got %b@%h exp %b@%h", n, r_be0, r_a0, ebe[0], w[0]); end
      if (nexp == 2) begin
        checks++; if (r_be1 !== ebe[1] || r_a1 !== w[1]) begin
          errors++; $display("FAIL rnd_acc1 #%0d got %b@%h exp %b@%h", n, r_be1, r_a1, ebe[1], w[1]); end
      end
      checks++; if (r_mwe !== ((nexp == 2) ? {we, we} : {1'b0, we})) begin
        errors++; $display("FAIL rnd_we #%0d got %b exp we %b n %0d", n, r_mwe, we, nexp); end
      if (we) begin
        lm = lanes(ebe[0]);
        checks++; if ((r_wd0 & lm) !== ewd[0] || (r_wd1 & lanes(ebe[1])) !== ewd[1]) begin
          errors++; $display("FAIL rnd_wdata #%0d got %h %h exp %h %h", n, r_wd0 & lm, r_wd1 & lanes(ebe[1]), ewd[0], ewd[1]); end
        for (int i = 0; i < size; i++) begin
          b = addr + 32'(i);
          model_words[b[5:2]][8*b[1:0] +: 8] = wd[8*i +: 8];
        end
      end
      checks++; if (r_rdata !== exp_rd || r_err !== 1'b0 || r_extra !== 1'b0) begin
        errors++; $display("FAIL rnd_resp #%0d got %h err %b extra %b exp %h 0 0", n, r_rdata, r_err, r_extra, exp_rd); end
    end
    for (int j = 0; j < 16; j++) begin
      checks++; if (ram[j] !== model_words[j]) begin
        errors++; $display("FAIL rnd_ram word %0d got %h exp %h", j, ram[j], model_words[j]); end
    end
  endtask

  initial begin
    test_reset();
    plan_image();
    test_lw_aligned();
    test_lh_cross();
    test_lb();
    test_wrap();
    test_sw_cross();
    test_reject();
    plan_image();
    test_back_to_back();
    test_reset_acc1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
